// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// UART receive front end: synchronizes the serial line, finds the start edge,
// samples each bit at its centre and delivers the deframed word with a
// one-cycle rx_valid strobe, plus one-cycle framing/parity error pulses.
// Optional parity support is compiled in by defining UART_RX_PARITY_EN;
// without it the frame is start + WORD_LENGTH data bits + stop and
// parity_error is held at 0.
module uart_rx_deserializer #(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_error,
    output logic                   parity_error,
    output logic                   busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    // Terminal counts: half a bit to reach the start-bit centre, then a full bit per sample
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_LENGTH - 1);

    // Reject parameter values the centre-sampling scheme cannot support
    if (CLKS_PER_BIT < 4 || WORD_LENGTH < 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_rx_deserializer: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    logic [CNT_W-1:0]       clk_cnt;
    logic [CNT_W-1:0]       clk_cnt_next;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_cnt_next;
    logic [WORD_LENGTH-1:0] shift_reg;
    logic [WORD_LENGTH-1:0] shift_next;
    logic [WORD_LENGTH-1:0] data_next;
    logic                   valid_next;
    logic                   ferr_next;
    logic                   perr_next;
    logic                   parity_bad;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bit;
    logic                   parity_bit_next;
    logic                   parity_expected;
`endif

    // Two-flop synchronizer plus one-cycle history for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Parity check against the assembled word (even: ^data, odd: ~^data)
    always_comb begin
`ifdef UART_RX_PARITY_EN
        parity_expected = (PARITY_ODD != 0) ? ~^shift_reg : ^shift_reg;
        parity_bad      = (parity_bit != parity_expected);
`else
        parity_bad      = 1'b0;
`endif
    end

    // Next-state and datapath decisions; each state waits for its sample point
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        data_next    = rx_data;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        perr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = rx_sync ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {rx_sync, shift_reg[WORD_LENGTH-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_next    = '0;
                    parity_bit_next = rx_sync;
                    state_next      = STOP;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                    ferr_next    = !rx_sync;
                    perr_next    = parity_bad;
                    valid_next   = rx_sync && !parity_bad;
                    if (rx_sync && !parity_bad) begin
                        data_next = shift_reg;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clk_cnt_next = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any frame silently
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            clk_cnt      <= clk_cnt_next;
            bit_cnt      <= bit_cnt_next;
            shift_reg    <= shift_next;
            rx_data      <= data_next;
            rx_valid     <= valid_next;
            frame_error  <= ferr_next;
            parity_error <= perr_next;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= parity_bit_next;
`endif
        end
    end

    assign busy = (state != IDLE);

endmodule
